rv32i_mem_arbiter: RTL and testbench
====================================

# rv32i_mem_arbiter

Arbiter that shares one single-ported unified memory between the instruction-fetch (IF) port and the load/store (LS) port of `rv32i_pipeline`. It sits between the pipeline's two memory masters and the memory macro. It sequences one outstanding transaction at a time, gives LS priority with starvation protection for IF, and drops in-flight fetches when the pipeline redirects.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width. `DATA_W/8` byte enables.
- `STARVE_MAX`, default 4: number of consecutive LS grants, while IF is waiting, after which IF wins. Legal range 1..15.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `if_req` in 1: fetch request; held until granted.
- `if_addr` in ADDR_W: fetch address.
- `if_gnt` out 1: fetch accepted this cycle.
- `if_rvalid` out 1: fetch data valid.
- `if_rdata` out DATA_W: fetch data.
- `if_flush` in 1: pipeline redirect; kill pending or in-flight fetch.
- `ls_req` in 1: load/store request; held until granted.
- `ls_we` in 1: 1 = store.
- `ls_be` in DATA_W/8: store byte enables.
- `ls_addr` in ADDR_W: load/store address.
- `ls_wdata` in DATA_W: store data.
- `ls_gnt` out 1: load/store accepted this cycle.
- `ls_rvalid` out 1: load data valid, or store completion.
- `ls_rdata` out DATA_W: load data.
- `mem_req` out 1: memory command strobe (one cycle per transaction).
- `mem_we` out 1: memory write enable.
- `mem_be` out DATA_W/8: memory byte enables.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rvalid` in 1: response from memory. Arrives 1 or more cycles after `mem_req`, for reads and writes.
- `mem_rdata` in DATA_W: memory read data.

## Operation
FSM states:
- IDLE:
  - Winner = LS if `ls_req` and not (`if_req` and `starve_cnt`==STARVE_MAX); otherwise IF if `if_req` and not `if_flush`.
  - On a win: drive `mem_*` from the winner, pulse the winner's gnt, and go to BUSY_LS or BUSY_IF.
- BUSY_LS: wait for `mem_rvalid`, then pulse `ls_rvalid`, pass `ls_rdata` = `mem_rdata`, and go to IDLE.
- BUSY_IF: wait for `mem_rvalid`, then pulse `if_rvalid` unless `drop` is set, and go to IDLE. `drop` clears on exit.

Fetch flush:
- `if_flush` in BUSY_IF, before or in the same cycle as `mem_rvalid`, sets/forces `drop`, so `if_rvalid` stays 0 for that response.
- `if_flush` in IDLE blocks the IF grant that cycle. LS may still be granted.

Starvation counter `starve_cnt` (4 bits):
- Increments on each LS grant while `if_req` is high.
- Clears on an IF grant, or on any cycle in IDLE where `if_req` is low.
- Saturates at STARVE_MAX.

Other rules:
- `mem_req` is never asserted outside IDLE. At most one outstanding transaction.
- `mem_rvalid` in IDLE is a protocol error and is ignored. No rvalid is forwarded.
- When not granted, `mem_we`, `mem_be`, `mem_addr` and `mem_wdata` are 0.
- `if_rdata` and `ls_rdata` pass `mem_rdata` unconditionally. Consumers qualify them with rvalid.

## Timing
- Reset: state IDLE, `starve_cnt`=0, `drop`=0. All outputs are 0: gnt, rvalid and `mem_req` combinationally from state, and data follows.
- Reset mid-transaction aborts it. A later stray `mem_rvalid` is ignored (state IDLE).
- Grant is combinational: `req`→`gnt`/`mem_req` in the same cycle, only in IDLE.
- Response is combinational: `mem_rvalid`→`*_rvalid` in the same cycle.
- The FSM returns to IDLE on the edge after `mem_rvalid`. The earliest next grant is the cycle after rvalid.
- Throughput is one transaction per (memory latency + 1) cycles.
- Request inputs are sampled only in IDLE. Requesters must hold them stable until gnt.

## Structure
- Package `rv32i_pkg` holds the state enum `arb_state_e` {ARB_IDLE, ARB_BUSY_IF, ARB_BUSY_LS} and the width constant `XLEN`=32.
- Single module; no sub-module. The priority/starvation logic is small enough to stay inline.

## Test plan
- Reset with `if_req`=1 held → no gnt, `mem_req`=0 until `rst_n` rises; IF granted on the first IDLE cycle.
- `if_req`=`ls_req`=1 continuously, with LS re-requesting after each response, memory latency 1 → grant sequence LS,LS,LS,LS,IF,LS… (STARVE_MAX=4).
- LS store: `ls_we`=1, `ls_be`=4'b0011, `ls_addr`=0x100, `ls_wdata`=0xDEADBEEF → `mem_we`=1 with identical `mem_be`/`addr`/`wdata`; `ls_rvalid` pulses with `mem_rvalid` 3 cycles later.
- IF fetch at 0x40 granted, `if_flush` pulsed the next cycle, memory returns 0x00000013 → `if_rvalid` stays 0. A new fetch at 0x80 then completes normally with `if_rvalid`=1.
- `if_flush`=1 coincident with `if_req` in IDLE and `ls_req`=0 → no grant that cycle; IF is granted the next cycle after the flush drops.
- Spurious `mem_rvalid` in IDLE → both rvalids stay 0; state stays IDLE.

Source files
------------

// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
//   Shared types and constants for the rv32i memory subsystem.
//   - XLEN        : architectural register / bus width.
//   - arb_state_e : states of the IF/LS memory arbiter FSM.
// ---------------------------------------------------------------------------
package rv32i_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY_IF = 2'd1,
        ARB_BUSY_LS = 2'd2
    } arb_state_e;

endpackage : rv32i_pkg

// File: rtl/rv32i_mem_arbiter.sv
// ---------------------------------------------------------------------------
// rv32i_mem_arbiter
//   Shares one single-ported unified memory between the instruction-fetch (IF)
//   port and the load/store (LS) port of the pipeline. One transaction is
//   outstanding at a time. LS has priority, but once LS has been granted
//   STARVE_MAX times in a row while IF was waiting, IF wins the next
//   arbitration. A pipeline redirect (if_flush) kills a pending or in-flight
//   fetch so its data never reaches the pipeline.
//
// Handshake (both master ports):
//   A master raises *_req with its command and holds it stable until *_gnt.
//   *_gnt is a single-cycle combinational acceptance, only issued in IDLE.
//   *_rvalid pulses for one cycle, combinationally with mem_rvalid, carrying
//   load/fetch data on *_rdata (stores complete with ls_rvalid, data unused).
//   mem_req is a one-cycle command strobe; the memory answers with mem_rvalid
//   one or more cycles later, for both reads and writes.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   if_req/if_addr/if_gnt           fetch command
//   if_rvalid/if_rdata              fetch response
//   if_flush                        pipeline redirect
//   ls_req/ls_we/ls_be/ls_addr/
//   ls_wdata/ls_gnt                 load/store command
//   ls_rvalid/ls_rdata              load/store response
//   mem_req/mem_we/mem_be/mem_addr/
//   mem_wdata                       memory command
//   mem_rvalid/mem_rdata            memory response
// ---------------------------------------------------------------------------
module rv32i_mem_arbiter
    import rv32i_pkg::*;
#(
    parameter int ADDR_W     = XLEN,
    parameter int DATA_W     = XLEN,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                if_flush,

    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [DATA_W/8-1:0] ls_be,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,

    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arb_state_e  state_q, state_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        drop_q, drop_d;
    logic        ls_win, if_win;
    logic        if_killed;

    // Read data is a pure pass-through; consumers qualify it with rvalid.
    assign if_rdata = mem_rdata;
    assign ls_rdata = mem_rdata;

    // A flush arriving in the same cycle as the response must also kill it,
    // so the registered drop flag is combined with the live flush input.
    assign if_killed = drop_q | if_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            starve_cnt_q <= 4'd0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            drop_q       <= drop_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        drop_d       = drop_q;
        ls_win       = 1'b0;
        if_win       = 1'b0;
        if_gnt       = 1'b0;
        ls_gnt       = 1'b0;
        if_rvalid    = 1'b0;
        ls_rvalid    = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_be       = '0;
        mem_addr     = '0;
        mem_wdata    = '0;

        unique case (state_q)
            ARB_IDLE: begin
                // Grants are combinational from the request inputs; while
                // reset is held the register already reads IDLE, so the
                // grant path is gated with rst_n to keep all outputs quiet.
                if (rst_n) begin
                    ls_win = ls_req && !(if_req && (starve_cnt_q == STARVE_LIM));
                    if_win = !ls_win && if_req && !if_flush;
                end

                if (ls_win) begin
                    ls_gnt    = 1'b1;
                    mem_req   = 1'b1;
                    mem_we    = ls_we;
                    mem_be    = ls_be;
                    mem_addr  = ls_addr;
                    mem_wdata = ls_wdata;
                    state_d   = ARB_BUSY_LS;
                end else if (if_win) begin
                    // A fetch is a full-word read: all lanes enabled, no data.
                    if_gnt    = 1'b1;
                    mem_req   = 1'b1;
                    mem_be    = '1;
                    mem_addr  = if_addr;
                    state_d   = ARB_BUSY_IF;
                end

                // Count LS wins that IF had to sit through; any cycle with
                // IF idle or IF served restarts the streak.
                if (!if_req || if_win) begin
                    starve_cnt_d = 4'd0;
                end else if (ls_win && (starve_cnt_q != STARVE_LIM)) begin
                    starve_cnt_d = starve_cnt_q + 4'd1;
                end
            end

            ARB_BUSY_IF: begin
                drop_d = if_killed;
                if (mem_rvalid) begin
                    if_rvalid = !if_killed;
                    drop_d    = 1'b0;
                    state_d   = ARB_IDLE;
                end
            end

            ARB_BUSY_LS: begin
                if (mem_rvalid) begin
                    ls_rvalid = 1'b1;
                    state_d   = ARB_IDLE;
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

endmodule : rv32i_mem_arbiter

// File: tb/tb_rv32i_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rv32i_mem_arbiter
//   Self-checking bench for rv32i_mem_arbiter. A memory responder answers
//   commands with a configurable latency, a reference model predicts grants
//   and response data from the arbitration rules, and a monitor pops the
//   expected-response queue whenever the DUT presents an rvalid.
// ---------------------------------------------------------------------------
module tb_rv32i_mem_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int EXP_W      = 34;   // {is_if, check_data, data[31:0]}

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_flush;
  logic        ls_req;
  logic        ls_we;
  logic [3:0]  ls_be;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  rv32i_mem_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .if_flush  (if_flush),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_be     (ls_be),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_gnt    (ls_gnt),
    .ls_rvalid (ls_rvalid),
    .ls_rdata  (ls_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata)
  );

  // ---------------- bench state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [EXP_W-1:0] exp_q[$];
  logic [7:0]       grant_log[$];

  logic [31:0] ref_mem [64];
  logic        m_busy;
  logic        m_port;        // 1 = fetch in flight
  logic        m_drop;
  int          streak;
  logic        last_if_gnt;
  logic        last_ls_gnt;

  int          lat_min;
  int          lat_max;
  int          stray_req;
  int          stray_done;

  function automatic logic [31:0] init_word(input int i);
    if (i == 16) return 32'h0000_0013;   // word at 0x40
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory responder ----------------
  initial begin : responder
    logic [31:0] mem [64];
    logic [31:0] rd;
    logic [5:0]  idx;
    int          lat;
    for (int i = 0; i < 64; i++) mem[i] = init_word(i);
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    stray_done = 0;
    forever begin
      @(negedge clk);
      if (rst_n && mem_req) begin
        idx = mem_addr[7:2];
        if (mem_we) begin
          for (int b = 0; b < 4; b++)
            if (mem_be[b]) mem[idx][8*b +: 8] = mem_wdata[8*b +: 8];
        end
        rd  = mem[idx];
        lat = $urandom_range(lat_max, lat_min);
        repeat (lat) @(posedge clk);
        #1;
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
      end else if (stray_req != stray_done) begin
        stray_done++;
        @(posedge clk);
        #1;
        mem_rvalid = 1'b1;
        mem_rdata  = $urandom;
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
      end
    end
  end

  // ---------------- reference model ----------------
  initial begin : ref_model
    logic       e_ls, e_if;
    logic [5:0] idx;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    m_busy = 1'b0; m_port = 1'b0; m_drop = 1'b0; streak = 0;
    last_if_gnt = 1'b0; last_ls_gnt = 1'b0;
    forever begin
      @(negedge clk);
      last_if_gnt = 1'b0;
      last_ls_gnt = 1'b0;
      if (!rst_n) begin
        check("reset_outputs", {if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_req, mem_we, mem_be}, 0);
        check("reset_mem_bus", {mem_addr, mem_wdata}, 0);
        m_busy = 1'b0; m_drop = 1'b0; streak = 0;
        exp_q.delete();
      end else if (!m_busy) begin
        e_ls = ls_req && !(if_req && streak >= STARVE_MAX);
        e_if = !e_ls && if_req && !if_flush;
        check("grant", {if_gnt, ls_gnt, mem_req}, {e_if, e_ls, e_if || e_ls});
        if (e_ls) begin
          check("ls_mem_cmd", {mem_we, mem_be, mem_addr}, {ls_we, ls_be, ls_addr});
          check("ls_mem_wdata", mem_wdata, ls_wdata);
          idx = ls_addr[7:2];
          exp_q.push_back({1'b0, !ls_we, ref_mem[idx]});
          if (ls_we) begin
            for (int b = 0; b < 4; b++)
              if (ls_be[b]) ref_mem[idx][8*b +: 8] = ls_wdata[8*b +: 8];
          end
          m_busy = 1'b1; m_port = 1'b0;
          streak = if_req ? streak + 1 : 0;
          grant_log.push_back(8'h4C);
        end else if (e_if) begin
          check("if_mem_cmd", {mem_we, mem_addr, mem_wdata}, {1'b0, if_addr, 32'h0});
          exp_q.push_back({1'b1, 1'b1, ref_mem[if_addr[7:2]]});
          m_busy = 1'b1; m_port = 1'b1; streak = 0;
          grant_log.push_back(8'h49);
        end else begin
          check("idle_mem_bus", |{mem_we, mem_be, mem_addr, mem_wdata}, 0);
          if (!if_req) streak = 0;
        end
        last_if_gnt = if_gnt;
        last_ls_gnt = ls_gnt;
      end else begin
        check("busy_quiet", {if_gnt, ls_gnt, mem_req}, 0);
        if (m_port && if_flush && !m_drop) begin
          m_drop = 1'b1;
          void'(exp_q.pop_back());
        end
        if (mem_rvalid) begin
          m_busy = 1'b0;
          m_drop = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic [EXP_W-1:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && (if_rvalid || ls_rvalid)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rvalid", {if_rvalid, ls_rvalid}, 0);
        end else begin
          e = exp_q.pop_front();
          check("rvalid_port", {if_rvalid, ls_rvalid}, e[33] ? 2'b10 : 2'b01);
          if (e[32]) check("rdata", e[33] ? if_rdata : ls_rdata, e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int p_if, input int p_ls, input int p_fl);
    @(posedge clk);
    #1;
    if (last_if_gnt) if_req = 1'b0;
    if (last_ls_gnt) ls_req = 1'b0;
    if (!if_req && $urandom_range(99, 0) < p_if) begin
      if_req  = 1'b1;
      if_addr = {24'h0, 6'($urandom_range(63, 0)), 2'b00};
    end
    if (!ls_req && $urandom_range(99, 0) < p_ls) begin
      ls_req   = 1'b1;
      ls_we    = 1'($urandom_range(1, 0));
      ls_be    = 4'($urandom_range(15, 1));
      ls_addr  = {24'h0, 6'($urandom_range(63, 0)), 2'b00};
      ls_wdata = $urandom;
    end
    if_flush = ($urandom_range(99, 0) < p_fl);
  endtask

  task automatic idle_bus();
    int n = 0;
    step(0, 0, 0);
    while ((if_req || ls_req || m_busy) && n < 60) begin
      step(0, 0, 0);
      n++;
    end
    if (n >= 60) check("idle_bus_timeout", n, 0);
  endtask

  task automatic wait_rvalid(input string name, input logic want_if);
    logic seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = want_if ? if_rvalid : ls_rvalid;
    end
    check(name, seen, 1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    logic [7:0] exp_pat [6];
    logic       seen;
    int         base;
    int         n;

    exp_pat = '{8'h4C, 8'h4C, 8'h4C, 8'h4C, 8'h49, 8'h4C};
    rst_n = 1'b0;
    if_req = 1'b1; if_addr = 32'h10; if_flush = 1'b0;
    ls_req = 1'b0; ls_we = 1'b0; ls_be = 4'h0; ls_addr = 32'h0; ls_wdata = 32'h0;
    lat_min = 1; lat_max = 1; stray_req = 0;

    // Reset held with a fetch pending: no grant until release.
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("first_if_gnt", {if_gnt, mem_req}, 2'b11);
    @(posedge clk);
    #1;
    if_req = 1'b0;
    idle_bus();

    // Both masters saturating, latency 1: starvation protection pattern.
    base = grant_log.size();
    repeat (14) step(100, 100, 0);
    idle_bus();
    for (int i = 0; i < 6; i++) begin
      if (grant_log.size() > base + i) check("starve_pattern", grant_log[base + i], exp_pat[i]);
      else check("starve_pattern_missing", i, 99);
    end

    // Store with byte enables, latency 3.
    lat_min = 3; lat_max = 3;
    ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'b0011; ls_addr = 32'h100; ls_wdata = 32'hDEADBEEF;
    @(negedge clk);
    check("store_gnt", ls_gnt, 1);
    check("store_mem_cmd", {mem_req, mem_we, mem_be, mem_addr}, {1'b1, 1'b1, 4'b0011, 32'h100});
    check("store_mem_wdata", mem_wdata, 32'hDEADBEEF);
    @(posedge clk);
    #1;
    ls_req = 1'b0; ls_we = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 10) begin
      @(negedge clk);
      n++;
      seen = ls_rvalid;
    end
    check("store_rvalid_latency", n, 3);
    @(posedge clk);
    #1;
    idle_bus();

    // Fetch killed by a flush the cycle after its grant.
    if_req = 1'b1; if_addr = 32'h40;
    @(negedge clk);
    check("flush_fetch_gnt", if_gnt, 1);
    @(posedge clk);
    #1;
    if_req = 1'b0; if_flush = 1'b1;
    @(posedge clk);
    #1;
    if_flush = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (if_rvalid) seen = 1'b1;
    end
    check("flush_drop", seen, 0);
    @(posedge clk);
    #1;
    if_req = 1'b1; if_addr = 32'h80;
    @(negedge clk);
    check("refetch_gnt", if_gnt, 1);
    @(posedge clk);
    #1;
    if_req = 1'b0;
    wait_rvalid("refetch_rvalid", 1'b1);
    idle_bus();

    // Flush coincident with a fetch request in IDLE blocks that grant only.
    lat_min = 2; lat_max = 2;
    if_req = 1'b1; if_flush = 1'b1; if_addr = 32'h84;
    @(negedge clk);
    check("flush_blocks_gnt", {if_gnt, mem_req}, 2'b00);
    @(posedge clk);
    #1;
    if_flush = 1'b0;
    @(negedge clk);
    check("gnt_after_flush", if_gnt, 1);
    @(posedge clk);
    #1;
    if_req = 1'b0;
    wait_rvalid("after_flush_rvalid", 1'b1);
    idle_bus();

    // Stray memory response in IDLE.
    stray_req++;
    @(negedge clk);
    @(negedge clk);
    check("stray_rvalid", {if_rvalid, ls_rvalid}, 2'b00);
    @(posedge clk);
    #1;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h20;
    @(negedge clk);
    check("gnt_after_stray", ls_gnt, 1);
    @(posedge clk);
    #1;
    ls_req = 1'b0;
    wait_rvalid("load_after_stray", 1'b0);
    idle_bus();

    // Reset in the middle of a load; the late response must be ignored.
    lat_min = 6; lat_max = 6;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h30;
    @(negedge clk);
    check("abort_gnt", ls_gnt, 1);
    @(posedge clk);
    #1;
    ls_req = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (if_rvalid || ls_rvalid) seen = 1'b1;
    end
    check("abort_no_rvalid", seen, 0);
    @(posedge clk);
    #1;

    // Randomized traffic with flushes and variable latency.
    lat_min = 1; lat_max = 4;
    repeat (2000) step(55, 45, 8);
    idle_bus();
    repeat (3) step(0, 0, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rv32i_mem_arbiter
